// File: rtl/dmem_pkg.sv
// Package shared by the data-memory responder files.
//   dmem_state_t  : access FSM states (wait-state mode only)
//   MMIO_CNT_ADDR : byte address of the free-running cycle counter
//   addr_fault()  : alignment / range decode of a byte address
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_FFF0;

    // True when the address is misaligned, has a bit set above the word-index
    // field, or selects a word index at or beyond the array depth.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input int unsigned idx_w,
                                        input int unsigned depth);
        logic [31:0] upper;
        logic [31:0] idx;
        upper = addr >> (idx_w + 2);
        idx   = (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
        return (addr[1:0] != 2'b00) || (upper != 32'd0) || (idx >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the core datapath (master) and the data memory (slave).
//   req   : access request, held by the master until ready
//   we    : 1 = store word, 0 = load word
//   addr  : byte address
//   wdata : store data
//   rdata : load data, valid when ready & ~we & ~err
//   ready : access complete this cycle
//   err   : access faulted, valid only with ready
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (output req, we, addr, wdata, input rdata, ready, err);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage: asynchronous read port, synchronous write port.
// Contents are not reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read word index
//   rdata_o  : read data (combinational)
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port. Decodes the byte
// address, serves word loads/stores from dmem_array and answers with a
// req/ready handshake after WAIT_STATES cycles (0 = combinational ready).
// Optional feature: macro DMEM_MMIO_EN adds a free-running cycle counter
// readable at MMIO_CNT_ADDR; without it that address faults.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : dmem_responder_if slave (req/we/addr/wdata in, rdata/ready/err out)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic [31:0]      cyc_q;
    logic             arr_we;
    logic [IDX_W-1:0] arr_waddr;
    logic [IDX_W-1:0] arr_raddr;
    logic [31:0]      arr_wdata;
    logic [31:0]      arr_rdata;

    dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .raddr_i (arr_raddr),
        .rdata_o (arr_rdata)
    );

    function automatic logic is_mmio(input logic [31:0] a);
        return MMIO_EN && (a == MMIO_CNT_ADDR);
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return addr_fault(a, IDX_W, DEPTH) && !is_mmio(a);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return a[IDX_W+1:2];
    endfunction

    // Value returned by a load: 0 on fault, counter on MMIO hit, else memory.
    function automatic logic [31:0] load_val(input logic [31:0] a,
                                             input logic [31:0] mem_word,
                                             input logic [31:0] cyc);
        if (is_fault(a)) return 32'd0;
        if (is_mmio(a))  return cyc;
        return mem_word;
    endfunction

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_q <= 32'd0;
        else        cyc_q <= cyc_q + 32'd1;
    end
`else
    assign cyc_q = 32'd0;
`endif

    if (WAIT_STATES == 0) begin : g_zero_wait
        assign arr_raddr = word_idx(bus.addr);
        assign arr_waddr = word_idx(bus.addr);
        assign arr_wdata = bus.wdata;
        assign arr_we    = bus.req & bus.we & ~is_fault(bus.addr) & ~is_mmio(bus.addr);
        assign bus.ready = bus.req;
        assign bus.err   = bus.req & is_fault(bus.addr);
        assign bus.rdata = load_val(bus.addr, arr_rdata, cyc_q);
    end else begin : g_wait
        localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

        dmem_state_t      state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [31:0]      addr_q, addr_d;
        logic [31:0]      wdata_q, wdata_d;
        logic [31:0]      rdata_q, rdata_d;
        logic             we_q, we_d;
        logic             enter_done;
        logic [31:0]      cur_addr;
        logic             cur_we;

        // The access that is about to reach DONE: live inputs when accepted
        // straight from IDLE (WAIT_STATES==1), otherwise the captured request.
        assign cur_addr  = (state_q == IDLE) ? bus.addr : addr_q;
        assign cur_we    = (state_q == IDLE) ? bus.we   : we_q;

        assign arr_raddr = word_idx(cur_addr);
        assign arr_waddr = word_idx(addr_q);
        assign arr_wdata = wdata_q;
        assign arr_we    = (state_q == DONE) & we_q & ~is_fault(addr_q) & ~is_mmio(addr_q);

        assign bus.ready = (state_q == DONE);
        assign bus.err   = (state_q == DONE) & is_fault(addr_q);
        assign bus.rdata = rdata_q;

        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            addr_d     = addr_q;
            we_d       = we_q;
            wdata_d    = wdata_q;
            rdata_d    = rdata_q;
            enter_done = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        addr_d  = bus.addr;
                        we_d    = bus.we;
                        wdata_d = bus.wdata;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                        if (WAIT_STATES == 1) begin
                            state_d    = DONE;
                            enter_done = 1'b1;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            // rdata is loaded on entry to DONE so it is already valid in the
            // ready cycle; cyc_q+1 is the counter value during that cycle.
            if (enter_done && !cur_we) begin
                rdata_d = load_val(cur_addr, arr_rdata, cyc_q + 32'd1);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                addr_q  <= 32'd0;
                we_q    <= 1'b0;
                wdata_q <= 32'd0;
                rdata_q <= 32'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                addr_q  <= addr_d;
                we_q    <= we_d;
                wdata_q <= wdata_d;
                rdata_q <= rdata_d;
            end
        end
    end
endmodule
